// File: rtl/opll_audio_pkg.sv
// Shared constants and types for the OPLL audio output stage.
package opll_audio_pkg;

    localparam int SLOT_BITS  = 16;
    localparam int FRAME_BITS = 32;

    typedef logic signed [15:0] opll_sample_t;

    localparam logic [15:0] PDM_OFFSET = 16'h8000;

    // Two's complement to offset binary: flipping the sign bit maps -32768..32767 onto 0..65535.
    function automatic logic [15:0] to_offset_binary(input logic [15:0] s);
        return s ^ PDM_OFFSET;
    endfunction

endpackage

// File: rtl/opll_audio_serializer_if.sv
// Signal bundle between the OPLL core side and the audio serializer (sample in, I2S/PDM pins out).
interface opll_audio_serializer_if;
    import opll_audio_pkg::*;

    opll_sample_t acc_signed;
    logic         acc_strb;
    logic         clr_ovr;
    logic         i2s_bclk;
    logic         i2s_lrck;
    logic         i2s_sdata;
    logic         ovr;
    logic         pdm_out;

    modport master (
        output acc_signed, acc_strb, clr_ovr,
        input  i2s_bclk, i2s_lrck, i2s_sdata, ovr, pdm_out
    );

    modport slave (
        input  acc_signed, acc_strb, clr_ovr,
        output i2s_bclk, i2s_lrck, i2s_sdata, ovr, pdm_out
    );

endinterface

// File: rtl/opll_dsm1.sv
// First-order delta-sigma modulator: the carry out of a free-running 16-bit accumulator
// gives a 1-bit stream whose ones-density is din/65536.
module opll_dsm1 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    output logic        dout
);

    logic [15:0] acc_reg;
    logic [16:0] sum;

    assign sum = {1'b0, acc_reg} + {1'b0, din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            dout    <= 1'b0;
        end else begin
            acc_reg <= sum[15:0];
            dout    <= sum[16];
        end
    end

endmodule

// File: rtl/opll_audio_serializer.sv
// Captures OPLL accumulator samples and streams them as mono-duplicated 16-bit I2S.
// Define OPLL_AUDIO_PDM_EN to also build the 1-bit delta-sigma output on pdm_out.
module opll_audio_serializer
    import opll_audio_pkg::*;
#(
    parameter int BCLK_DIV = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    opll_audio_serializer_if.slave  bus
);

    localparam int                 DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic                 strb_q_reg;
    logic                 pend_reg;
    logic [SAMPLE_W-1:0]  hold_reg;
    logic [SAMPLE_W-1:0]  word_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [4:0]           bit_cnt_reg;
    logic                 bclk_reg;
    logic                 lrck_reg;
    logic                 sdata_reg;
    logic                 ovr_reg;

    logic                 capture;
    logic                 wrap;
    logic                 fall;
    logic [4:0]           bit_cnt_next;
    logic                 frame_start;
    logic [SAMPLE_W-1:0]  word_next;
    logic                 sdata_next;

    assign capture      = bus.acc_strb & ~strb_q_reg;
    assign wrap         = (div_cnt_reg == DIV_LAST);
    assign fall         = wrap & bclk_reg;
    assign bit_cnt_next = bit_cnt_reg + 5'd1;
    assign frame_start  = fall && (bit_cnt_next == 5'd0);
    // The MSB of a new frame must come from the word being loaded this very cycle.
    assign word_next    = frame_start ? hold_reg : word_reg;
    // Both slots index the same word: 15-k for the left slot, 31-k for the right one.
    assign sdata_next   = word_next[4'd15 - bit_cnt_next[3:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_q_reg <= 1'b0;
            hold_reg   <= '0;
        end else begin
            strb_q_reg <= bus.acc_strb;
            if (capture) begin
                hold_reg <= bus.acc_signed;
            end
        end
    end

    // A capture coinciding with a frame load leaves the new sample pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg <= 1'b0;
        end else if (capture) begin
            pend_reg <= 1'b1;
        end else if (frame_start) begin
            pend_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
        end else if (wrap) begin
            div_cnt_reg <= '0;
            bclk_reg    <= ~bclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Starting at 31 makes the first falling BCLK open a left slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg <= 5'd31;
            word_reg    <= '0;
            sdata_reg   <= 1'b0;
            lrck_reg    <= 1'b0;
        end else if (fall) begin
            bit_cnt_reg <= bit_cnt_next;
            word_reg    <= word_next;
            sdata_reg   <= sdata_next;
            if (bit_cnt_next == 5'd31) begin
                lrck_reg <= 1'b0;
            end else if (bit_cnt_next == 5'd15) begin
                lrck_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_reg <= 1'b0;
        end else if (capture && pend_reg) begin
            ovr_reg <= 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_reg <= 1'b0;
        end
    end

    assign bus.i2s_bclk  = bclk_reg;
    assign bus.i2s_lrck  = lrck_reg;
    assign bus.i2s_sdata = sdata_reg;
    assign bus.ovr       = ovr_reg;

`ifdef OPLL_AUDIO_PDM_EN
    logic pdm_bit;

    opll_dsm1 u_dsm1 (
        .clk  (clk),
        .rst  (rst),
        .din  (to_offset_binary(hold_reg)),
        .dout (pdm_bit)
    );

    assign bus.pdm_out = pdm_bit;
`else
    assign bus.pdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_opll_audio_serializer.sv
// Scoreboard bench: stimulus queues the expected slot words, a monitor rebuilds each slot from the pins.
module tb_opll_audio_serializer;

    logic clk;
    logic rst;

    opll_audio_serializer_if bus ();

    opll_audio_serializer #(
        .BCLK_DIV (2),
        .SAMPLE_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    int          mon_k    = 31;
    int          fall_cnt = 0;
    logic        prev_bclk = 1'b0;
    logic [15:0] shreg = '0;
    bit          mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        logic [15:0] e;
        #1;
        if (rst) begin
            prev_bclk = 1'b0;
            mon_k     = 31;
            shreg     = '0;
        end else begin
            if (prev_bclk && !bus.i2s_bclk) begin
                mon_k = (mon_k + 1) % 32;
                fall_cnt++;
                chk($sformatf("lrck k=%0d", mon_k), {31'd0, bus.i2s_lrck},
                    {31'd0, (mon_k >= 15 && mon_k <= 30)});
`ifndef OPLL_AUDIO_PDM_EN
                chk("pdm_const0", {31'd0, bus.pdm_out}, 32'd0);
`endif
                shreg = {shreg[14:0], bus.i2s_sdata};
                if (mon_en && (mon_k == 15 || mon_k == 31)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_slot", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(mon_k == 15 ? "left_slot" : "right_slot", {16'd0, shreg}, {16'd0, e});
                        $display("slot %s word %h", mon_k == 15 ? "L" : "R", shreg);
                    end
                end
            end
            prev_bclk = bus.i2s_bclk;
        end
    end

    task automatic wait_k(input int k);
        int last;
        last = fall_cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fall_cnt != last) begin
                last = fall_cnt;
                if (mon_k == k) return;
            end
        end
        chk($sformatf("timeout_wait_k%0d", k), 32'd1, 32'd0);
    endtask

    task automatic push2(input logic [15:0] w);
        exp_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic pulse(input logic [15:0] v);
        bus.acc_signed = v;
        bus.acc_strb   = 1'b1;
        @(negedge clk);
        bus.acc_strb   = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bclk"},  {31'd0, bus.i2s_bclk},  32'd0);
        chk({tag, "_lrck"},  {31'd0, bus.i2s_lrck},  32'd0);
        chk({tag, "_sdata"}, {31'd0, bus.i2s_sdata}, 32'd0);
        chk({tag, "_ovr"},   {31'd0, bus.ovr},       32'd0);
        chk({tag, "_pdm"},   {31'd0, bus.pdm_out},   32'd0);
    endtask

    // After release: BCLK rises on the 2nd edge and first falls on the 4th, opening frame 0.
    task automatic release_and_check_start();
        rst = 1'b0;
        push2(16'h0000);
        @(negedge clk);
        chk("bclk_edge1", {31'd0, bus.i2s_bclk}, 32'd0);
        @(negedge clk);
        chk("bclk_edge2", {31'd0, bus.i2s_bclk}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("bclk_first_fall", {31'd0, bus.i2s_bclk}, 32'd0);
        chk("lrck_first_fall", {31'd0, bus.i2s_lrck}, 32'd0);
    endtask

    initial begin
        int ones;
        int zeros;
        bus.acc_signed = '0;
        bus.acc_strb   = 1'b0;
        bus.clr_ovr    = 1'b0;
        rst            = 1'b1;
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        release_and_check_start();

        // Basic frame
        wait_k(4);
        pulse(16'hA5C3);
        push2(16'hA5C3);
        chk("ovr_after_a5c3", {31'd0, bus.ovr}, 32'd0);

        // Long strobe: value changes while the strobe is still high
        wait_k(0);
        wait_k(2);
        bus.acc_signed = 16'h0001;
        bus.acc_strb   = 1'b1;
        @(negedge clk);
        bus.acc_signed = 16'h7FFF;
        repeat (9) @(negedge clk);
        bus.acc_strb   = 1'b0;
        push2(16'h0001);
        chk("ovr_long_strobe", {31'd0, bus.ovr}, 32'd0);

        // Overrun: two captures in one frame
        wait_k(0);
        wait_k(4);
        pulse(16'h1111);
        chk("ovr_first_capture", {31'd0, bus.ovr}, 32'd0);
        wait_k(8);
        pulse(16'h2222);
        chk("ovr_set", {31'd0, bus.ovr}, 32'd1);
        push2(16'h2222);

        wait_k(0);
        chk("ovr_sticky", {31'd0, bus.ovr}, 32'd1);
        bus.clr_ovr = 1'b1;
        @(negedge clk);
        bus.clr_ovr = 1'b0;
        chk("ovr_cleared", {31'd0, bus.ovr}, 32'd0);
        push2(16'h2222);

        // Underrun: no strobes, the held word repeats
        wait_k(0);
        push2(16'h2222);
        wait_k(0);
        push2(16'h2222);

        // Reset mid-frame
        wait_k(0);
        wait_k(7);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        release_and_check_start();
        wait_k(4);
        pulse(16'hBEEF);
        push2(16'hBEEF);

        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

`ifdef OPLL_AUDIO_PDM_EN
        mon_en = 1'b0;
        pulse(16'h8000);
        repeat (4) @(negedge clk);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.pdm_out) ones++;
        end
        chk("pdm_min_all_zero", ones, 32'd0);

        pulse(16'h0000);
        repeat (4) @(negedge clk);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.pdm_out) ones++;
        end
        chk("pdm_mid_half", {31'd0, (ones >= 127 && ones <= 129)}, 32'd1);

        pulse(16'h7FFF);
        repeat (4) @(negedge clk);
        zeros = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!bus.pdm_out) zeros++;
        end
        chk("pdm_max_rare_zero", {31'd0, (zeros <= 1)}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
